// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the mini-MIPS instruction/data memory port arbiter.
package mips_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OWN_W      = 2;

   typedef enum logic [OWN_W-1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   typedef enum logic {
      DM_PRIO  = 1'b0,
      IF_FORCE = 1'b1
   } arb_state_t;

   // Starve counter width; keeps one bit when the guard is disabled.
   function automatic int unsigned cnt_width(input int unsigned lim);
      return (lim > 0) ? $clog2(lim + 1) : 1;
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-owner tag delay line, aligned with the memory read latency.
module rd_tag_pipe
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OWN_W-1:0] tag_in,
   output logic [OWN_W-1:0] tag_out
);

   logic [OWN_W-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (DM); DM has priority,
// a starvation guard forces an IF grant, and read data is routed back by owner tag.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned    BE_W    = DATA_W / 8;
   localparam int unsigned    CNT_W   = cnt_width(STARVE_LIM);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
   owner_t           tag_push, tag_pop;
   logic [OWN_W-1:0] tag_pop_raw;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= DM_PRIO;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Next state and starvation counter
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      if (if_gnt || !if_req) begin
         starve_cnt_nxt = '0;
      end else if (dm_gnt && (starve_cnt != CNT_MAX)) begin
         starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
      case (state)
         IF_FORCE: begin
            if (if_gnt || !if_req) begin
               state_nxt      = DM_PRIO;
               starve_cnt_nxt = '0;
            end
         end
         default: begin
            // Switch on the count about to be stored so the forced grant lands on the next cycle.
            if ((STARVE_LIM > 0) && (starve_cnt_nxt == CNT_MAX)) state_nxt = IF_FORCE;
         end
      endcase
   end

   // Grant outputs
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      case (state)
         IF_FORCE: begin
            if (if_req)      if_gnt = 1'b1;
            else if (dm_req) dm_gnt = 1'b1;
         end
         default: begin
            if (dm_req)      dm_gnt = 1'b1;
            else if (if_req) if_gnt = 1'b1;
         end
      endcase
   end

   // Memory-side mux; everything reads zero while idle
   always_comb begin
      mem_en    = if_gnt | dm_gnt;
      mem_we    = dm_gnt & dm_we;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_gnt) begin
         mem_be    = dm_we ? dm_be : {BE_W{1'b1}};
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_be    = {BE_W{1'b1}};
         mem_addr  = if_addr;
      end
   end

   always_comb begin
      tag_push = OWN_NONE;
      if (if_gnt)                tag_push = OWN_IF;
      else if (dm_gnt && !dm_we) tag_push = OWN_DM;
   end

   rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_push),
      .tag_out (tag_pop_raw)
   );

   assign tag_pop   = owner_t'(tag_pop_raw);
   assign if_rvalid = (tag_pop == OWN_IF);
   assign dm_rvalid = (tag_pop == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1/STARVE_LIM=4 and RD_LAT=2/STARVE_LIM=0)
// driven by directed and random requesters, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = DW / 8;
   localparam int unsigned NI    = 2;
   localparam int unsigned DEPTH = 1 << AW;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } rd_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [BW-1:0] be;
   } dm_op_t;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic int lim_of(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   function automatic logic [DW-1:0] init_word(input int k, input int i);
      return (DW'(i) * 32'h0101_0101) ^ ((k == 0) ? 32'h0 : 32'h5A5A_0000);
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          if_req    [NI];
   logic [AW-1:0] if_addr   [NI];
   logic          if_gnt    [NI];
   logic          if_rvalid [NI];
   logic [DW-1:0] if_rdata  [NI];
   logic          dm_req    [NI];
   logic          dm_we     [NI];
   logic [AW-1:0] dm_addr   [NI];
   logic [DW-1:0] dm_wdata  [NI];
   logic [BW-1:0] dm_be     [NI];
   logic          dm_gnt    [NI];
   logic          dm_rvalid [NI];
   logic [DW-1:0] dm_rdata  [NI];
   logic          mem_en    [NI];
   logic          mem_we    [NI];
   logic [BW-1:0] mem_be    [NI];
   logic [AW-1:0] mem_addr  [NI];
   logic [DW-1:0] mem_wdata [NI];
   logic [DW-1:0] mem_rdata [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : 2;
      localparam int unsigned LIM = (g == 0) ? 4 : 0;

      logic [DW-1:0] bram    [DEPTH];
      logic [DW-1:0] rd_pipe [LAT];

      mem_port_arbiter #(
         .ADDR_W     (AW),
         .DATA_W     (DW),
         .RD_LAT     (LAT),
         .STARVE_LIM (LIM)
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n),
         .if_req    (if_req[g]),
         .if_addr   (if_addr[g]),
         .if_gnt    (if_gnt[g]),
         .if_rvalid (if_rvalid[g]),
         .if_rdata  (if_rdata[g]),
         .dm_req    (dm_req[g]),
         .dm_we     (dm_we[g]),
         .dm_addr   (dm_addr[g]),
         .dm_wdata  (dm_wdata[g]),
         .dm_be     (dm_be[g]),
         .dm_gnt    (dm_gnt[g]),
         .dm_rvalid (dm_rvalid[g]),
         .dm_rdata  (dm_rdata[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_be    (mem_be[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      initial for (int i = 0; i < DEPTH; i++) bram[i] = init_word(g, i);

      // Single-port BRAM with LAT-cycle read latency
      always @(posedge clk) begin
         if (mem_en[g]) begin
            if (mem_we[g]) begin
               for (int b = 0; b < BW; b++)
                  if (mem_be[g][b]) bram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            rd_pipe[0] <= bram[mem_addr[g]];
         end else begin
            rd_pipe[0] <= '0;
         end
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end

      assign mem_rdata[g] = rd_pipe[LAT-1];
   end

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int unsigned   p_if     = 0;
   int unsigned   p_dm     = 0;
   bit            drop_dm  = 1'b0;
   int            streak   [NI];
   bit            e_if     [NI];
   bit            e_dm     [NI];
   rd_t           qi       [NI][$];
   rd_t           qd       [NI][$];
   logic [AW-1:0] if_scr   [NI][$];
   dm_op_t        dm_scr   [NI][$];
   logic [DW-1:0] got_ld   [NI][$];
   logic [DW-1:0] shadow   [NI][DEPTH];
   int            n_ig     [NI];
   int            n_dg     [NI];
   int            n_irv    [NI];
   int            n_drv    [NI];
   int            b_ig     [NI];
   int            b_dg     [NI];
   int            b_irv    [NI];
   int            b_drv    [NI];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic snap();
      for (int k = 0; k < NI; k++) begin
         b_ig[k] = n_ig[k]; b_dg[k] = n_dg[k]; b_irv[k] = n_irv[k]; b_drv[k] = n_drv[k];
      end
   endtask

   // One clock cycle: drive requesters, check against the model, then advance the model.
   task automatic step(input bit do_rst);
      dm_op_t        op;
      bit            erv;
      logic [DW-1:0] ed;
      logic [BW-1:0] ebe;
      logic [AW-1:0] ea;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         if (e_if[k]) if_req[k] = 1'b0;
         if (e_dm[k]) dm_req[k] = 1'b0;
         if (do_rst) begin
            if_req[k] = 1'b0;
            dm_req[k] = 1'b0;
            qi[k].delete();
            qd[k].delete();
            streak[k] = 0;
         end else begin
            if (!if_req[k]) begin
               if (if_scr[k].size() > 0) begin
                  if_addr[k] = if_scr[k].pop_front();
                  if_req[k]  = 1'b1;
               end else if ($urandom_range(99) < p_if) begin
                  if_addr[k] = AW'($urandom_range(31));
                  if_req[k]  = 1'b1;
               end
            end
            if (drop_dm) begin
               dm_req[k] = 1'b0;
            end else if (!dm_req[k]) begin
               if (dm_scr[k].size() > 0) begin
                  op = dm_scr[k].pop_front();
                  dm_req[k] = 1'b1;
               end else if ($urandom_range(99) < p_dm) begin
                  op.we = 1'($urandom_range(1));
                  op.a  = AW'($urandom_range(31));
                  op.wd = $urandom;
                  op.be = BW'($urandom_range(15));
                  dm_req[k] = 1'b1;
               end
               if (dm_req[k]) begin
                  dm_we[k] = op.we; dm_addr[k] = op.a; dm_wdata[k] = op.wd; dm_be[k] = op.be;
               end
            end
         end
      end
      rst_n = !do_rst;
      #1;
      for (int k = 0; k < NI; k++) begin
         e_if[k] = if_req[k] && (!dm_req[k] || (lim_of(k) > 0 && streak[k] == lim_of(k)));
         e_dm[k] = dm_req[k] && !e_if[k];
         check($sformatf("u%0d.if_gnt", k), 64'(if_gnt[k]), 64'(e_if[k]));
         check($sformatf("u%0d.dm_gnt", k), 64'(dm_gnt[k]), 64'(e_dm[k]));
         check($sformatf("u%0d.mem_en", k), 64'(mem_en[k]), 64'(e_if[k] | e_dm[k]));
         check($sformatf("u%0d.mem_we", k), 64'(mem_we[k]), 64'(e_dm[k] & dm_we[k]));
         ebe = (e_dm[k] && dm_we[k]) ? dm_be[k] : ((e_if[k] || e_dm[k]) ? '1 : '0);
         check($sformatf("u%0d.mem_be", k), 64'(mem_be[k]), 64'(ebe));
         ea = e_dm[k] ? dm_addr[k] : (e_if[k] ? if_addr[k] : '0);
         check($sformatf("u%0d.mem_addr", k), 64'(mem_addr[k]), 64'(ea));
         if (!(e_dm[k] && !dm_we[k]))
            check($sformatf("u%0d.mem_wdata", k), 64'(mem_wdata[k]),
                  64'(e_dm[k] ? dm_wdata[k] : '0));
         n_ig[k] += int'(if_gnt[k]);
         n_dg[k] += int'(dm_gnt[k]);
         n_irv[k] += int'(if_rvalid[k]);
         n_drv[k] += int'(dm_rvalid[k]);
         erv = (qi[k].size() > 0) && (qi[k][0].due == cyc);
         ed  = erv ? qi[k][0].d : '0;
         if (erv) void'(qi[k].pop_front());
         check($sformatf("u%0d.if_rvalid", k), 64'(if_rvalid[k]), 64'(erv));
         check($sformatf("u%0d.if_rdata", k), 64'(if_rdata[k]), 64'(ed));
         erv = (qd[k].size() > 0) && (qd[k][0].due == cyc);
         ed  = erv ? qd[k][0].d : '0;
         if (erv) void'(qd[k].pop_front());
         check($sformatf("u%0d.dm_rvalid", k), 64'(dm_rvalid[k]), 64'(erv));
         check($sformatf("u%0d.dm_rdata", k), 64'(dm_rdata[k]), 64'(ed));
         if (dm_rvalid[k]) got_ld[k].push_back(dm_rdata[k]);
      end
      @(posedge clk);
      if (!do_rst) begin
         for (int k = 0; k < NI; k++) begin
            rd_t r;
            if (e_if[k]) begin
               r.due = cyc + lat_of(k);
               r.d   = shadow[k][if_addr[k]];
               qi[k].push_back(r);
            end
            if (e_dm[k]) begin
               if (dm_we[k]) begin
                  for (int b = 0; b < BW; b++)
                     if (dm_be[k][b]) shadow[k][dm_addr[k]][8*b +: 8] = dm_wdata[k][8*b +: 8];
               end else begin
                  r.due = cyc + lat_of(k);
                  r.d   = shadow[k][dm_addr[k]];
                  qd[k].push_back(r);
               end
            end
            if (e_if[k] || !if_req[k]) streak[k] = 0;
            else if (e_dm[k] && streak[k] < lim_of(k)) streak[k]++;
         end
      end
      cyc++;
   endtask

   function automatic dm_op_t mk_op(input logic we, input int a, input logic [DW-1:0] wd,
                                    input logic [BW-1:0] be);
      dm_op_t o;
      o.we = we; o.a = AW'(a); o.wd = wd; o.be = be;
      return o;
   endfunction

   initial begin
      for (int k = 0; k < NI; k++) begin
         if_req[k] = 1'b0; if_addr[k] = '0;
         dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0; dm_be[k] = '0;
         e_if[k] = 1'b0; e_dm[k] = 1'b0; streak[k] = 0;
         n_ig[k] = 0; n_dg[k] = 0; n_irv[k] = 0; n_drv[k] = 0;
         for (int i = 0; i < DEPTH; i++) shadow[k][i] = init_word(k, i);
      end

      // Reset state, then idle
      step(1'b1);
      step(1'b1);
      repeat (2) step(1'b0);

      // IF only, addresses 0..7 back-to-back
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 8; a++) if_scr[k].push_back(AW'(a));
      snap();
      repeat (8) step(1'b0);
      for (int k = 0; k < NI; k++) check($sformatf("u%0d.if_only_gnts", k), 64'(n_ig[k] - b_ig[k]), 64'd8);
      repeat (4) step(1'b0);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d.if_only_rvalids", k), 64'(n_irv[k] - b_irv[k]), 64'd8);
         check($sformatf("u%0d.if_only_dm_rvalids", k), 64'(n_drv[k] - b_drv[k]), 64'd0);
      end

      // Continuous contention for 20 cycles
      p_if = 100; p_dm = 100;
      snap();
      repeat (20) step(1'b0);
      check("u0.contention_if_gnts", 64'(n_ig[0] - b_ig[0]), 64'd4);
      check("u0.contention_dm_gnts", 64'(n_dg[0] - b_dg[0]), 64'd16);
      check("u1.contention_if_gnts", 64'(n_ig[1] - b_ig[1]), 64'd0);
      check("u1.contention_dm_gnts", 64'(n_dg[1] - b_dg[1]), 64'd20);

      // Dropping dm_req hands the port to the waiting fetch in the same cycle
      p_dm = 0; drop_dm = 1'b1;
      snap();
      step(1'b0);
      drop_dm = 1'b0; p_if = 0;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d.drop_dm_if_gnt", k), 64'(n_ig[k] - b_ig[k]), 64'd1);
         check($sformatf("u%0d.drop_dm_dm_gnt", k), 64'(n_dg[k] - b_dg[k]), 64'd0);
      end
      repeat (5) step(1'b0);

      // Store/load with byte enables, interleaved with a fetch of the same word
      for (int k = 0; k < NI; k++) begin
         got_ld[k].delete();
         dm_scr[k].push_back(mk_op(1'b1, 5, 32'hDEAD_BEEF, 4'b1111));
         dm_scr[k].push_back(mk_op(1'b0, 5, 32'h0, 4'b0000));
         dm_scr[k].push_back(mk_op(1'b1, 5, 32'h0000_00AA, 4'b0001));
         dm_scr[k].push_back(mk_op(1'b0, 5, 32'h0, 4'b1010));
         if_scr[k].push_back(AW'(5));
      end
      repeat (12) step(1'b0);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d.st_ld_count", k), 64'(got_ld[k].size()), 64'd2);
         if (got_ld[k].size() == 2) begin
            check($sformatf("u%0d.ld_full", k), 64'(got_ld[k][0]), 64'h0000_0000_DEAD_BEEF);
            check($sformatf("u%0d.ld_byte0", k), 64'(got_ld[k][1]), 64'h0000_0000_DEAD_BEAA);
         end
      end

      // Reset one cycle after a fetch grant: the read never returns
      if_scr[0].push_back(AW'(3));
      if_scr[1].push_back(AW'(3));
      snap();
      step(1'b0);
      step(1'b1);
      repeat (5) step(1'b0);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d.rst_mid_gnt", k), 64'(n_ig[k] - b_ig[k]), 64'd1);
         check($sformatf("u%0d.rst_mid_rvalid", k), 64'(n_irv[k] - b_irv[k]), 64'd0);
      end

      // After reset the starve guard starts from zero again
      p_if = 100; p_dm = 100;
      snap();
      repeat (10) step(1'b0);
      check("u0.post_rst_if_gnts", 64'(n_ig[0] - b_ig[0]), 64'd2);
      check("u1.post_rst_if_gnts", 64'(n_ig[1] - b_ig[1]), 64'd0);

      // Random traffic
      p_if = 50; p_dm = 50;
      repeat (1500) step(1'b0);
      p_if = 0; p_dm = 0;
      repeat (8) step(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
